smg_scan_ctrl: RTL and testbench

//  Time-multiplexed 6-digit seven-segment scan engine; downstream stage of the smg_ip AXI-lite register file.

---
 rtl/smg_pkg.sv | 44 ++++
 rtl/smg_scan_ctrl_if.sv | 23 ++
 rtl/smg_hex_decode.sv | 13 +
 rtl/smg_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_smg_scan_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/smg_pkg.sv
// Shared types and constants for the seven-segment scan engine.
// Latency: n/a (package only).
// Backpressure: n/a.
package smg_pkg;

    localparam int NUM_DIGITS = 6;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_t;

    // One complete display image; active and shadow buffers both hold this.
    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] data;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blank;
    } disp_frame_t;

    // Segment patterns for 0..F, bit0 = a, active-high.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [7:0] seg_pin(input logic [7:0] raw, input logic act_low);
        return act_low ? ~raw : raw;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] scan_pin(input logic [NUM_DIGITS-1:0] raw,
                                                       input logic act_low);
        return act_low ? ~raw : raw;
    endfunction

    function automatic logic [7:0] seg_off(input logic act_low);
        return seg_pin(8'h00, act_low);
    endfunction

    function automatic logic [NUM_DIGITS-1:0] scan_off(input logic act_low);
        return scan_pin('0, act_low);
    endfunction

endpackage

// File: rtl/smg_scan_ctrl_if.sv
// Load/enable port of the scan engine, driven by the register file.
// Latency: n/a (signal bundle).
// Backpressure: Disp_Ready low while a shadow image is waiting for a frame boundary.
interface smg_scan_ctrl_if;

    logic [4*smg_pkg::NUM_DIGITS-1:0] Disp_Data;
    logic [smg_pkg::NUM_DIGITS-1:0]   Disp_Dp;
    logic [smg_pkg::NUM_DIGITS-1:0]   Disp_Blank;
    logic                             Disp_Valid;
    logic                             Disp_Ready;
    logic                             Disp_Enable;

    modport master (
        output Disp_Data, Disp_Dp, Disp_Blank, Disp_Valid, Disp_Enable,
        input  Disp_Ready
    );

    modport slave (
        input  Disp_Data, Disp_Dp, Disp_Blank, Disp_Valid, Disp_Enable,
        output Disp_Ready
    );

endinterface

// File: rtl/smg_hex_decode.sv
// Nibble to seven-segment pattern (bit0 = a, active-high).
// Latency: combinational.
// Backpressure: none.
module smg_hex_decode
    import smg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/smg_scan_ctrl.sv
// Six-digit multiplexed seven-segment scanner with double-buffered load.
// Latency: pins follow scan state by one cycle; loads become visible at the next frame start.
// Backpressure: Disp_Ready drops while a shadow image is pending.
module smg_scan_ctrl
    import smg_pkg::*;
#(
    parameter int C_NUM_DIGITS      = 6,
    parameter int C_SCAN_DIV        = 50000,
    parameter int C_BLANK_CYCLES    = 16,
    parameter bit C_SEG_ACTIVE_LOW  = 1'b1,
    parameter bit C_SCAN_ACTIVE_LOW = 1'b1
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    smg_scan_ctrl_if.slave        disp,
    output logic [7:0]            SMG_Data,
    output logic [NUM_DIGITS-1:0] Scan_Sig,
    output logic                  Frame_Done
);

    localparam int                    CNT_W      = (C_SCAN_DIV > 2) ? $clog2(C_SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(C_SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(C_BLANK_CYCLES - 1);
    localparam logic [2:0]            DIG_LAST   = 3'(C_NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_OFF    = seg_off(C_SEG_ACTIVE_LOW);
    localparam logic [NUM_DIGITS-1:0] SCAN_OFF   = scan_off(C_SCAN_ACTIVE_LOW);

    scan_state_t           state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [2:0]            digit, digit_nxt;
    logic                  frame_end;
    disp_frame_t           active, shadow, load;
    logic                  pending;
    logic                  accept;
    logic [6:0]            hex_seg;
    logic [3:0]            nibble;
    logic                  lit;
    logic [7:0]            seg_raw;
    logic [NUM_DIGITS-1:0] scan_raw;

    assign load            = {disp.Disp_Data, disp.Disp_Dp, disp.Disp_Blank};
    assign disp.Disp_Ready = !pending;
    assign accept          = disp.Disp_Valid && !pending;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state <= IDLE;
            cnt   <= '0;
            digit <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            digit <= digit_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        digit_nxt = digit;
        frame_end = 1'b0;
        if (!disp.Disp_Enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            digit_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    digit_nxt = '0;
                end
                BLANK: begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == BLANK_LAST) state_nxt = SHOW;
                end
                SHOW: begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = BLANK;
                        cnt_nxt   = '0;
                        if (digit == DIG_LAST) begin
                            digit_nxt = '0;
                            frame_end = 1'b1;
                        end else begin
                            digit_nxt = digit + 3'd1;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Shadow is promoted at a frame boundary or when the display is switched off;
    // in IDLE nothing is on screen so a load can go straight to the active image.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            if (pending && (!disp.Disp_Enable || frame_end)) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            if (accept) begin
                if (state == IDLE) begin
                    active <= load;
                end else begin
                    shadow  <= load;
                    pending <= 1'b1;
                end
            end
        end
    end

    assign nibble = active.data[{digit, 2'b00} +: 4];

    smg_hex_decode u_hex_decode (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    assign lit      = disp.Disp_Enable && (state == SHOW) && !active.blank[digit];
    assign seg_raw  = {active.dp[digit], hex_seg};
    assign scan_raw = NUM_DIGITS'(1) << digit;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            SMG_Data   <= SEG_OFF;
            Scan_Sig   <= SCAN_OFF;
            Frame_Done <= 1'b0;
        end else begin
            SMG_Data   <= lit ? seg_pin(seg_raw, C_SEG_ACTIVE_LOW) : SEG_OFF;
            Scan_Sig   <= lit ? scan_pin(scan_raw, C_SCAN_ACTIVE_LOW) : SCAN_OFF;
            Frame_Done <= frame_end;
        end
    end

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Bench for smg_scan_ctrl: frame-position reference model plus directed literal checks.
module tb_smg_scan_ctrl;

    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int NDIG  = 6;
    localparam int FRAME = DIV * NDIG;

    logic       clk;
    logic       rst_n;
    logic [7:0] smg_data;
    logic [5:0] scan_sig;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int e0     = 0;
    bit chk_on = 0;

    smg_scan_ctrl_if disp_if ();

    smg_scan_ctrl #(
        .C_NUM_DIGITS      (6),
        .C_SCAN_DIV        (DIV),
        .C_BLANK_CYCLES    (BLK),
        .C_SEG_ACTIVE_LOW  (1'b1),
        .C_SCAN_ACTIVE_LOW (1'b1)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .disp          (disp_if),
        .SMG_Data      (smg_data),
        .Scan_Sig      (scan_sig),
        .Frame_Done    (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: position within a 48-cycle frame, active/shadow images.
    logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    bit          m_run;
    int          m_pos;
    bit          m_pend;
    logic [23:0] a_data, s_data;
    logic [5:0]  a_dp, a_blank, s_dp, s_blank;
    logic [7:0]  exp_seg;
    logic [5:0]  exp_scan;
    logic        exp_fd;
    logic        exp_rdy;

    task automatic m_reset();
        m_run = 0; m_pos = 0; m_pend = 0;
        a_data = '0; a_dp = '0; a_blank = '0;
        s_data = '0; s_dp = '0; s_blank = '0;
        exp_seg = 8'hFF; exp_scan = 6'h3F; exp_fd = 1'b0; exp_rdy = 1'b1;
    endtask

    task automatic m_step();
        bit acc, bnd, was_run, en;
        int d, ph;
        logic [3:0] nib;
        en  = disp_if.Disp_Enable;
        acc = disp_if.Disp_Valid && !m_pend;
        exp_seg = 8'hFF; exp_scan = 6'h3F; exp_fd = 1'b0;
        if (en && m_run) begin
            d  = m_pos / DIV;
            ph = m_pos % DIV;
            if (ph >= BLK && !a_blank[d]) begin
                nib      = a_data[4*d +: 4];
                exp_seg  = ~{a_dp[d], hex_tab[nib]};
                exp_scan = ~(6'b000001 << d);
            end
            exp_fd = (m_pos == FRAME - 1);
        end
        bnd     = en && m_run && (m_pos == FRAME - 1);
        was_run = m_run;
        if (!en) begin
            m_run = 0; m_pos = 0;
            if (m_pend) begin
                a_data = s_data; a_dp = s_dp; a_blank = s_blank; m_pend = 0;
            end
        end else if (!m_run) begin
            m_run = 1; m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
        end
        if (bnd && m_pend) begin
            a_data = s_data; a_dp = s_dp; a_blank = s_blank; m_pend = 0;
        end
        if (acc) begin
            if (!was_run) begin
                a_data = disp_if.Disp_Data; a_dp = disp_if.Disp_Dp; a_blank = disp_if.Disp_Blank;
            end else begin
                s_data = disp_if.Disp_Data; s_dp = disp_if.Disp_Dp; s_blank = disp_if.Disp_Blank;
                m_pend = 1;
            end
        end
        exp_rdy = !m_pend;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_on && rst_n) begin
                chk("model_smg",   {24'h0, smg_data},   {24'h0, exp_seg});
                chk("model_scan",  {26'h0, scan_sig},   {26'h0, exp_scan});
                chk("model_fd",    {31'h0, frame_done}, {31'h0, exp_fd});
                chk("model_ready", {31'h0, disp_if.Disp_Ready}, {31'h0, exp_rdy});
            end
        end
    end

    task automatic goto_edge(input int k);
        while (cyc < e0 + k + 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_load(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] bl);
        disp_if.Disp_Data  = d;
        disp_if.Disp_Dp    = dp;
        disp_if.Disp_Blank = bl;
        disp_if.Disp_Valid = 1'b1;
    endtask

    task automatic chk_pins(input string name, input logic [7:0] s, input logic [5:0] sc);
        chk({name, "_smg"},  {24'h0, smg_data}, {24'h0, s});
        chk({name, "_scan"}, {26'h0, scan_sig}, {26'h0, sc});
    endtask

    initial begin
        rst_n = 1'b0;
        disp_if.Disp_Data = '0; disp_if.Disp_Dp = '0; disp_if.Disp_Blank = '0;
        disp_if.Disp_Valid = 1'b0; disp_if.Disp_Enable = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_pins("reset", 8'hFF, 6'h3F);
        chk("reset_ready", {31'h0, disp_if.Disp_Ready}, 32'h1);
        chk("reset_fd",    {31'h0, frame_done},         32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_on = 1;

        // Load in IDLE, then enable scanning.
        @(negedge clk);
        drive_load(24'h543210, 6'h00, 6'h00);
        @(negedge clk);
        disp_if.Disp_Valid  = 1'b0;
        disp_if.Disp_Enable = 1'b1;
        e0 = cyc;
        goto_edge(2);  chk_pins("blank_d0", 8'hFF, 6'h3F);
        goto_edge(3);  chk_pins("show_d0",  8'hC0, 6'h3E);
        goto_edge(11); chk_pins("show_d1",  8'hF9, 6'h3D);
        goto_edge(47); chk("fd_early", {31'h0, frame_done}, 32'h0);
        goto_edge(48); chk("fd_48",    {31'h0, frame_done}, 32'h1);

        // Mid-frame load is held until the frame boundary; a second valid is ignored.
        goto_edge(58); @(negedge clk);
        drive_load(24'hFFFFFF, 6'h00, 6'h00);
        goto_edge(59); chk("ready_pend", {31'h0, disp_if.Disp_Ready}, 32'h0);
        @(negedge clk);
        drive_load(24'h111111, 6'h00, 6'h00);
        goto_edge(60); @(negedge clk);
        disp_if.Disp_Valid = 1'b0;
        goto_edge(95);  chk_pins("old_d5", 8'h92, 6'h1F);
        goto_edge(96);  chk("ready_after", {31'h0, disp_if.Disp_Ready}, 32'h1);
        goto_edge(99);  chk_pins("new_d0", 8'h8E, 6'h3E);
        goto_edge(107); chk_pins("new_d1", 8'h8E, 6'h3D);

        // Decimal point on digit0, digit1 blanked.
        goto_edge(110); @(negedge clk);
        drive_load(24'h543210, 6'b000001, 6'b000010);
        goto_edge(111); @(negedge clk);
        disp_if.Disp_Valid = 1'b0;
        goto_edge(147); chk_pins("dp_d0", 8'h40, 6'h3E);
        for (int k = 153; k <= 160; k++) begin
            goto_edge(k);
            chk_pins("blank_d1", 8'hFF, 6'h3F);
        end
        goto_edge(191); chk("fd_191", {31'h0, frame_done}, 32'h0);
        goto_edge(192); chk("fd_192", {31'h0, frame_done}, 32'h1);

        // Disable during digit3 with a pending image.
        goto_edge(195); @(negedge clk);
        drive_load(24'hABC789, 6'h00, 6'h00);
        goto_edge(196); @(negedge clk);
        disp_if.Disp_Valid = 1'b0;
        goto_edge(220); @(negedge clk);
        disp_if.Disp_Enable = 1'b0;
        goto_edge(221);
        chk_pins("dis", 8'hFF, 6'h3F);
        chk("dis_ready", {31'h0, disp_if.Disp_Ready}, 32'h1);
        chk("dis_fd",    {31'h0, frame_done},         32'h0);
        goto_edge(225); @(negedge clk);
        disp_if.Disp_Enable = 1'b1;
        e0 = cyc;
        goto_edge(2); chk_pins("reen_blank", 8'hFF, 6'h3F);
        goto_edge(3); chk_pins("reen_d0",    8'h90, 6'h3E);

        // Load accepted on the boundary cycle waits a full frame.
        goto_edge(47); @(negedge clk);
        drive_load(24'h000000, 6'h00, 6'h00);
        goto_edge(48);
        chk("bnd_ready", {31'h0, disp_if.Disp_Ready}, 32'h0);
        chk("bnd_fd",    {31'h0, frame_done},         32'h1);
        @(negedge clk);
        disp_if.Disp_Valid = 1'b0;
        goto_edge(51); chk_pins("bnd_old", 8'h90, 6'h3E);
        goto_edge(96); chk("bnd_fd2", {31'h0, frame_done}, 32'h1);
        goto_edge(99); chk_pins("bnd_new", 8'hC0, 6'h3E);

        // Asynchronous reset while a digit is lit.
        goto_edge(101); chk_pins("pre_rst", 8'hC0, 6'h3E);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_pins("async_rst", 8'hFF, 6'h3F);
        chk("async_rst_ready", {31'h0, disp_if.Disp_Ready}, 32'h1);
        chk("async_rst_fd",    {31'h0, frame_done},         32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (disp_if.Disp_Enable) begin
                if ($urandom_range(0, 399) == 0) disp_if.Disp_Enable = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                disp_if.Disp_Enable = 1'b1;
            end
            disp_if.Disp_Valid = ($urandom_range(0, 29) == 0);
            disp_if.Disp_Data  = 24'($urandom);
            disp_if.Disp_Dp    = 6'($urandom);
            disp_if.Disp_Blank = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00;
        end
        @(negedge clk);
        disp_if.Disp_Valid = 1'b0;
        @(posedge clk);
        #2;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
